// File: rtl/sd_tag_scanner.sv
// sd_tag_scanner: requests consecutive SD blocks from sd_card starting at
// START_BLK and scans each 512-byte stream for the TAG string. It reports
// the block and offset of the last byte of the first occurrence, or reports
// a miss after MAX_BLKS blocks.
// Optional feature macro: SCAN_CASE_FOLD_EN (fold 'a'..'z' to upper case
// before matching; TAG must then be upper case).
//
// state  | meaning
// S_IDLE | waiting for start after reset
// S_REQ  | one-cycle read request for block_addr
// S_RECV | consuming the 512 bytes of the current block
// S_NEXT | decide: finish or advance to the next block
// S_DONE | result held until the next accepted start
module sd_tag_scanner #(
  parameter logic [31:0]          START_BLK = 32'h2000,
  parameter int                   MAX_BLKS  = 1024,
  parameter int                   TAG_LEN   = 9,
  parameter logic [8*TAG_LEN-1:0] TAG       = "DCL_START"
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_finished,
  input  logic        start,
  output logic        rd_req,
  output logic [31:0] block_addr,
  input  logic [7:0]  sd_dout,
  input  logic        sd_valid,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] found_blk,
  output logic [8:0]  found_off
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [8*TAG_LEN-1:0]   shreg;
  logic [8*TAG_LEN-1:0]   shift_nxt;
  logic [8*TAG_LEN+7:0]   shift_wide;
  logic [9:0]             byte_cnt;
  logic [15:0]            blk_cnt;
  logic [7:0]             byte_in;
  logic                   launch;
  logic                   accept;
  logic                   last_byte;
  logic                   last_blk;
  logic                   tag_hit;

  // Byte conditioning, shift-register look-ahead and control decodes
  always_comb begin
    byte_in = sd_dout;
`ifdef SCAN_CASE_FOLD_EN
    if (sd_dout >= 8'h61 && sd_dout <= 8'h7A) begin
      byte_in = sd_dout - 8'h20;
    end
`endif
    // Concatenate then truncate so a single-byte tag needs no special case.
    shift_wide = {shreg, byte_in};
    shift_nxt  = shift_wide[8*TAG_LEN-1:0];
    tag_hit    = (shift_nxt == TAG);
    launch     = ((state == S_IDLE) || (state == S_DONE)) && start && init_finished;
    accept     = (state == S_RECV) && sd_valid;
    last_byte  = accept && (byte_cnt == 10'd511);
    last_blk   = (({1'b0, blk_cnt} + 17'd1) == 17'(MAX_BLKS));
  end

  // Next-state logic and the two state-decoded outputs
  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (launch) state_nxt = S_REQ;
      end
      S_REQ: begin
        rd_req    = 1'b1;
        busy      = 1'b1;
        state_nxt = S_RECV;
      end
      S_RECV: begin
        busy = 1'b1;
        if (last_byte) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        busy = 1'b1;
        // found is already registered here, including a hit on byte 511.
        if (found || last_blk) state_nxt = S_DONE;
        else                   state_nxt = S_REQ;
      end
      S_DONE: begin
        if (launch) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Scan datapath: shift register, counters, block address and result
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg      <= '0;
      byte_cnt   <= '0;
      blk_cnt    <= '0;
      block_addr <= START_BLK;
      done       <= 1'b0;
      found      <= 1'b0;
      found_blk  <= '0;
      found_off  <= '0;
    end else begin
      if (launch) begin
        shreg      <= '0;
        byte_cnt   <= '0;
        blk_cnt    <= '0;
        block_addr <= START_BLK;
        done       <= 1'b0;
        found      <= 1'b0;
      end
      // The shift register carries across blocks so a split tag still hits.
      if (accept) begin
        shreg    <= shift_nxt;
        byte_cnt <= last_byte ? 10'd0 : byte_cnt + 10'd1;
        if (tag_hit && !found) begin
          found     <= 1'b1;
          found_blk <= block_addr;
          found_off <= byte_cnt[8:0];
        end
      end
      if (state == S_NEXT) begin
        if (found || last_blk) begin
          done <= 1'b1;
        end else begin
          block_addr <= block_addr + 32'd1;
          blk_cnt    <= blk_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_tag_scanner.sv
// Directed bench for sd_tag_scanner. The bench plays the sd_card side:
// after each rd_req it streams a 512-byte block whose contents depend on
// the scenario and the requested block number. Two instances are used:
// the default configuration and one with MAX_BLKS = 4 for miss scenarios.
module tb_sd_tag_scanner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        init_finished;
  logic        start;
  logic [7:0]  sd_dout;
  logic        sd_valid;

  logic        rd_req,   rd_req_4;
  logic [31:0] block_addr, block_addr_4;
  logic        busy,     busy_4;
  logic        done,     done_4;
  logic        found,    found_4;
  logic [31:0] found_blk, found_blk_4;
  logic [8:0]  found_off, found_off_4;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  sd_tag_scanner dut (
    .clk(clk), .reset_n(reset_n), .init_finished(init_finished), .start(start),
    .rd_req(rd_req), .block_addr(block_addr), .sd_dout(sd_dout), .sd_valid(sd_valid),
    .busy(busy), .done(done), .found(found), .found_blk(found_blk), .found_off(found_off)
  );

  sd_tag_scanner #(.MAX_BLKS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .init_finished(init_finished), .start(start),
    .rd_req(rd_req_4), .block_addr(block_addr_4), .sd_dout(sd_dout), .sd_valid(sd_valid),
    .busy(busy_4), .done(done_4), .found(found_4), .found_blk(found_blk_4),
    .found_off(found_off_4)
  );

  // One comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rq(input int sel);
    return (sel == 1) ? rd_req_4 : rd_req;
  endfunction

  function automatic logic dn(input int sel);
    return (sel == 1) ? done_4 : done;
  endfunction

  function automatic logic [31:0] ba(input int sel);
    return (sel == 1) ? block_addr_4 : block_addr;
  endfunction

  function automatic logic bz(input int sel);
    return (sel == 1) ? busy_4 : busy;
  endfunction

  // Block contents: '.' filler with the tag placed per scenario
  function automatic logic [7:0] byte_at(input int scen, input logic [31:0] a, input int off);
    logic [71:0] t;
    logic [71:0] tl;
    logic [7:0]  b;
    t  = "DCL_START";
    tl = "dcl_start";
    b  = 8'h2E;
    case (scen)
      1: if (a == 32'h2000 && off >= 16 && off <= 24) b = t[8*(24-off) +: 8];
      2: begin
        if (a == 32'h2003 && off >= 508) b = t[8*(516-off) +: 8];
        if (a == 32'h2004 && off <= 4)   b = t[8*(4-off) +: 8];
      end
      4: begin
        if (a == 32'h2001 && off >= 503) b = t[8*(511-off) +: 8];
        if (a == 32'h2002 && off <= 8)   b = t[8*(8-off) +: 8];
      end
      5: if (a == 32'h2000 && off <= 8) b = tl[8*(8-off) +: 8];
      default: b = 8'h2E;
    endcase
    return b;
  endfunction

  task automatic reset_pulse();
    reset_n  = 1'b0;
    sd_valid = 1'b0;
    start    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Full scan on instance sel; all inputs change on negedges
  task automatic run_scan(input int scen, input int sel, output int nreq,
                          output logic [31:0] first_a, output logic [31:0] last_a);
    int t;
    logic [31:0] a;
    nreq    = 0;
    first_a = '0;
    last_a  = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int blk = 0; blk < 8; blk++) begin
      t = 0;
      while (!rq(sel) && !dn(sel) && t < 8) begin
        @(negedge clk);
        t++;
      end
      if (dn(sel)) begin
        chk("done_latency", t, 1);
        return;
      end
      if (t >= 8) begin
        chk("req_timeout", t, 0);
        return;
      end
      chk((nreq == 0) ? "start_to_req" : "byte_to_req", t, (nreq == 0) ? 0 : 1);
      a = ba(sel);
      if (nreq == 0) first_a = a;
      else chk("addr_step", a, last_a + 32'd1);
      last_a = a;
      nreq++;
      @(negedge clk);
      for (int i = 0; i < 512; i++) begin
        sd_dout  = byte_at(scen, a, i);
        sd_valid = 1'b1;
        @(negedge clk);
        if (i == 256) begin
          chk("addr_stable", ba(sel), a);
          chk("busy_mid", {31'd0, bz(sel)}, 1);
        end
      end
      sd_valid = 1'b0;
    end
    chk("too_many_blocks", nreq, 0);
  endtask

  int          nreq;
  logic [31:0] fa, la;

  initial begin
    reset_n       = 1'b0;
    init_finished = 1'b0;
    start         = 1'b0;
    sd_dout       = 8'h00;
    sd_valid      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rd_req", {31'd0, rd_req}, 0);
    chk("rst_block_addr", block_addr, 32'h2000);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_found", {31'd0, found}, 0);
    chk("rst_found_blk", found_blk, 0);
    chk("rst_found_off", {23'd0, found_off}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // start is ignored until init_finished
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("noinit_rd_req", {31'd0, rd_req}, 0);
    @(negedge clk);
    chk("noinit_busy", {31'd0, busy}, 0);
    init_finished = 1'b1;

    // Tag inside the first block
    run_scan(1, 0, nreq, fa, la);
    chk("s1_nreq", nreq, 1);
    chk("s1_done", {31'd0, done}, 1);
    chk("s1_found", {31'd0, found}, 1);
    chk("s1_found_blk", found_blk, 32'h2000);
    chk("s1_found_off", {23'd0, found_off}, 32'h018);
    chk("s1_busy", {31'd0, busy}, 0);

    // Tag split across blocks 0x2003/0x2004, started from S_DONE
    run_scan(2, 0, nreq, fa, la);
    chk("s2_nreq", nreq, 5);
    chk("s2_first", fa, 32'h2000);
    chk("s2_last", la, 32'h2004);
    chk("s2_found", {31'd0, found}, 1);
    chk("s2_found_blk", found_blk, 32'h2004);
    chk("s2_found_off", {23'd0, found_off}, 4);

    // Tag ending on byte 511 of 0x2001; 0x2002 holds another tag
    run_scan(4, 0, nreq, fa, la);
    chk("s4_nreq", nreq, 2);
    chk("s4_last", la, 32'h2001);
    chk("s4_found", {31'd0, found}, 1);
    chk("s4_found_blk", found_blk, 32'h2001);
    chk("s4_found_off", {23'd0, found_off}, 511);
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("s4_no_more_req", {31'd0, rd_req}, 0);
    chk("s4_done_held", {31'd0, done}, 1);
    chk("s4_off_held", {23'd0, found_off}, 511);

    // Reset during byte 200 of block 0x2001
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("r_req0", {31'd0, rd_req}, 1);
    chk("r_addr0", block_addr, 32'h2000);
    @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      sd_dout  = 8'h2E;
      sd_valid = 1'b1;
      @(negedge clk);
    end
    sd_valid = 1'b0;
    @(negedge clk);
    chk("r_req1", {31'd0, rd_req}, 1);
    chk("r_addr1", block_addr, 32'h2001);
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      sd_dout  = 8'h2E;
      sd_valid = 1'b1;
      @(negedge clk);
    end
    reset_n = 1'b0;
    @(negedge clk);
    chk("r_rd_req", {31'd0, rd_req}, 0);
    chk("r_block_addr", block_addr, 32'h2000);
    chk("r_busy", {31'd0, busy}, 0);
    chk("r_done", {31'd0, done}, 0);
    chk("r_found", {31'd0, found}, 0);
    chk("r_found_blk", found_blk, 0);
    chk("r_found_off", {23'd0, found_off}, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("r_stray_busy", {31'd0, busy}, 0);
    sd_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("r_restart_req", {31'd0, rd_req}, 1);
    chk("r_restart_addr", block_addr, 32'h2000);
    reset_pulse();

    // No tag, MAX_BLKS = 4
    run_scan(3, 1, nreq, fa, la);
    chk("s3_nreq", nreq, 4);
    chk("s3_first", fa, 32'h2000);
    chk("s3_last", la, 32'h2003);
    chk("s3_done", {31'd0, done_4}, 1);
    chk("s3_found", {31'd0, found_4}, 0);
    reset_pulse();

    // Lower-case tag at offsets 0..8
    run_scan(5, 1, nreq, fa, la);
    chk("s5_done", {31'd0, done_4}, 1);
`ifdef SCAN_CASE_FOLD_EN
    chk("s5_nreq", nreq, 1);
    chk("s5_found", {31'd0, found_4}, 1);
    chk("s5_found_blk", found_blk_4, 32'h2000);
    chk("s5_found_off", {23'd0, found_off_4}, 8);
`else
    chk("s5_nreq", nreq, 4);
    chk("s5_found", {31'd0, found_4}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
